obi_to_axil_bridge: RTL and testbench

//  Converts the core's OBI data port into a single AXI4-Lite master port for the peripheral interconnect.

---
 rtl/obi_to_axil_bridge_pkg.sv | 26 ++
 rtl/axil_timeout_counter.sv | 30 +++
 rtl/obi_to_axil_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_obi_to_axil_bridge.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_to_axil_bridge_pkg.sv
// Shared types and constants for the OBI to AXI4-Lite bridge.
package obi_to_axil_bridge_pkg;

    // Peripheral interconnect bus widths
    localparam int unsigned AXI4L_CONF_ADDR_WIDTH = 32;
    localparam int unsigned AXI4L_CONF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } obi_axil_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is reported to the core as an error
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_timeout_counter.sv
// Watchdog counter for the bridge: counts busy cycles and flags when LIMIT-1 is reached.
module axil_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear on a new transaction, count while waiting, hold once expired
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (en_i && !expired_o) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired_o = (r_cnt == LAST);

endmodule

// File: rtl/obi_to_axil_bridge.sv
// OBI data port to single AXI4-Lite master, one outstanding transaction.
// Optional watchdog enabled by defining OBI_TO_AXIL_TIMEOUT_EN.
module obi_to_axil_bridge
    import obi_to_axil_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = AXI4L_CONF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = AXI4L_CONF_DATA_WIDTH,
    parameter logic [2:0]  AXI_PROT       = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // OBI slave side
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,
    // AXI4-Lite master side
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic [2:0]              m_awprot_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [1:0]              m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [2:0]              m_arprot_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o
);

    obi_axil_state_e r_state;
    obi_axil_state_e w_state_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_be;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    r_aw_done;
    logic                    r_w_done;

    logic w_gnt;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_timeout;

    assign w_gnt   = data_req_i & rst_ni & (r_state == IDLE);
    assign w_aw_hs = m_awvalid_o & m_awready_i;
    assign w_w_hs  = m_wvalid_o & m_wready_i;
    assign w_b_hs  = m_bready_o & m_bvalid_i;
    assign w_r_hs  = m_rready_o & m_rvalid_i;

`ifdef OBI_TO_AXIL_TIMEOUT_EN
    logic w_busy;
    logic w_expired;

    assign w_busy = (r_state == WR_REQ) | (r_state == WR_RESP) |
                    (r_state == RD_REQ) | (r_state == RD_RESP);

    axil_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (w_gnt),
        .en_i      (w_busy),
        .expired_o (w_expired)
    );

    assign w_timeout = w_busy & w_expired;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a timeout pre-empts every waiting state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt) begin
                    w_state_next = data_we_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (w_timeout) begin
                    w_state_next = RSP;
                end else if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (w_timeout || w_b_hs) begin
                    w_state_next = RSP;
                end
            end
            RD_REQ: begin
                if (w_timeout) begin
                    w_state_next = RSP;
                end else if (m_arready_i) begin
                    w_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (w_timeout || w_r_hs) begin
                    w_state_next = RSP;
                end
            end
            RSP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode; AW and W valids retire independently via their done flags
    always_comb begin
        m_awvalid_o   = 1'b0;
        m_wvalid_o    = 1'b0;
        m_bready_o    = 1'b0;
        m_arvalid_o   = 1'b0;
        m_rready_o    = 1'b0;
        data_rvalid_o = 1'b0;
        case (r_state)
            WR_REQ: begin
                m_awvalid_o = ~r_aw_done & ~w_timeout;
                m_wvalid_o  = ~r_w_done & ~w_timeout;
            end
            WR_RESP: m_bready_o    = ~w_timeout;
            RD_REQ:  m_arvalid_o   = ~w_timeout;
            RD_RESP: m_rready_o    = ~w_timeout;
            RSP:     data_rvalid_o = 1'b1;
            default: ;
        endcase
    end

    // Request capture at grant, channel progress and response capture
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_gnt) begin
            r_addr    <= data_addr_i;
            r_wdata   <= data_wdata_i;
            r_be      <= data_be_i;
            // Cleared here so writes and timeouts return zero read data
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_b_hs) begin
                r_err <= resp_is_err(m_bresp_i);
            end else if (w_r_hs) begin
                r_rdata <= m_rdata_i;
                r_err   <= resp_is_err(m_rresp_i);
            end
        end
    end

    assign data_gnt_o   = w_gnt;
    assign data_rdata_o = r_rdata;
    assign data_err_o   = r_err & data_rvalid_o;

    assign m_awaddr_o = r_addr;
    assign m_awprot_o = AXI_PROT;
    assign m_wdata_o  = r_wdata;
    assign m_wstrb_o  = r_be;
    assign m_araddr_o = r_addr;
    assign m_arprot_o = AXI_PROT;

endmodule

// File: tb/tb_obi_to_axil_bridge.sv
// Self-checking bench for obi_to_axil_bridge: transaction-level model plus directed tests.
// The timeout test is compiled in when OBI_TO_AXIL_TIMEOUT_EN is defined.
module tb_obi_to_axil_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req = 1'b0;
    logic        data_gnt;
    logic [31:0] data_addr = '0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_wdata = '0;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    always #5 clk = ~clk;

    obi_to_axil_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .AXI_PROT       (3'b000),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_req_i    (data_req),
        .data_gnt_o    (data_gnt),
        .data_addr_i   (data_addr),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_wdata_i  (data_wdata),
        .data_rvalid_o (data_rvalid),
        .data_rdata_o  (data_rdata),
        .data_err_o    (data_err),
        .m_awaddr_o    (m_awaddr),
        .m_awprot_o    (m_awprot),
        .m_awvalid_o   (m_awvalid),
        .m_awready_i   (m_awready),
        .m_wdata_o     (m_wdata),
        .m_wstrb_o     (m_wstrb),
        .m_wvalid_o    (m_wvalid),
        .m_wready_i    (m_wready),
        .m_bresp_i     (m_bresp),
        .m_bvalid_i    (m_bvalid),
        .m_bready_o    (m_bready),
        .m_araddr_o    (m_araddr),
        .m_arprot_o    (m_arprot),
        .m_arvalid_o   (m_arvalid),
        .m_arready_i   (m_arready),
        .m_rdata_i     (m_rdata),
        .m_rresp_i     (m_rresp),
        .m_rvalid_i    (m_rvalid),
        .m_rready_o    (m_rready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // AXI slave knobs: *_lat = cycles a valid/ready waits before the slave answers
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    bit          ar_never = 0, r_force = 0;

    initial begin
        int awc = 0, wc = 0, arc = 0, bc = 0, rc = 0;
        forever begin
            @(negedge clk);
            awc = m_awvalid ? awc + 1 : 0;
            wc  = m_wvalid  ? wc + 1  : 0;
            arc = m_arvalid ? arc + 1 : 0;
            bc  = m_bready  ? bc + 1  : 0;
            rc  = m_rready  ? rc + 1  : 0;
            m_awready = m_awvalid && (awc > aw_lat);
            m_wready  = m_wvalid && (wc > w_lat);
            m_arready = m_arvalid && !ar_never && (arc > ar_lat);
            m_bvalid  = m_bready && (bc > b_lat);
            m_rvalid  = r_force || (m_rready && (rc > r_lat));
            m_bresp   = bresp_cfg;
            m_rresp   = rresp_cfg;
            m_rdata   = rdata_cfg;
        end
    end

    // Transaction-level model: what each OBI request must look like on AXI and what it returns
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        bit          err;
        bit          tmo;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   chk_en = 0;
    int   outst = 0;
    int   n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int   gnt_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, req_cyc = 0;
    int   gnt_log[$];
    int   rv_log[$];
    logic [31:0] cap_araddr, cap_wdata, cap_rdata;
    logic [3:0]  cap_wstrb;
    logic        cap_err;

    task automatic push_exp(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input bit tmo);
        txn_t t;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.be    = be;
        t.tmo   = tmo;
        t.rdata = (we || tmo) ? 32'h0 : rdata_cfg;
        t.err   = tmo ? 1'b1 : (we ? (bresp_cfg != 2'b00) : (rresp_cfg != 2'b00));
        exp_q.push_back(t);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                int  n_gnt_chk;
                bit  busy_tmo;
                n_gnt_chk = outst;
                chk("gnt", data_gnt, data_req && (n_gnt_chk == 0));
                busy_tmo = (outst == 1) && cur.tmo;
                if (!busy_tmo) begin
                    chk("awvalid", m_awvalid, (outst == 1) && cur.we && n_aw == 0);
                    chk("wvalid", m_wvalid, (outst == 1) && cur.we && n_w == 0);
                    chk("bready", m_bready, (outst == 1) && cur.we && n_aw == 1 && n_w == 1
                                            && n_b == 0);
                    chk("arvalid", m_arvalid, (outst == 1) && !cur.we && n_ar == 0);
                    chk("rready", m_rready, (outst == 1) && !cur.we && n_ar == 1 && n_r == 0);
                end
                if (m_awvalid) chk("awaddr", m_awaddr, cur.addr);
                if (m_wvalid) begin
                    chk("wdata", m_wdata, cur.wdata);
                    chk("wstrb", m_wstrb, cur.be);
                end
                if (m_arvalid) chk("araddr", m_araddr, cur.addr);
                if (outst == 0) chk("rvalid_idle", data_rvalid, 1'b0);
                else if (!cur.tmo) chk("rvalid", data_rvalid, cur.we ? (n_b == 1) : (n_r == 1));

                if (m_awvalid && m_awready) begin
                    chk("awprot", m_awprot, 3'b000);
                    n_aw++;
                    aw_hs_cyc = cyc;
                end
                if (m_wvalid && m_wready) begin
                    n_w++;
                    w_hs_cyc  = cyc;
                    cap_wdata = m_wdata;
                    cap_wstrb = m_wstrb;
                end
                if (m_arvalid && m_arready) begin
                    chk("arprot", m_arprot, 3'b000);
                    n_ar++;
                    cap_araddr = m_araddr;
                end
                if (m_bready && m_bvalid) n_b++;
                if (m_rready && m_rvalid) n_r++;

                if (data_rvalid && outst == 1) begin
                    chk("rdata", data_rdata, cur.rdata);
                    chk("err", data_err, cur.err);
                    if (cur.tmo) begin
                        chk("tmo_window", (cyc - gnt_cyc >= TMO) && (cyc - gnt_cyc <= TMO + 2),
                            1'b1);
                    end
                    cap_rdata = data_rdata;
                    cap_err   = data_err;
                    rv_log.push_back(cyc);
                    outst = 0;
                end

                if (data_gnt && exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    outst = 1;
                    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
                    gnt_cyc = cyc;
                    gnt_log.push_back(cyc);
                end
            end
        end
    end

    // Stimulus helpers; all driving happens on the falling edge
    task automatic wait_gnt();
        int n = 0;
        #2;
        while (!data_gnt && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!data_gnt) chk("gnt_bound", data_gnt, 1'b1);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        #2;
        while (!data_rvalid && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!data_rvalid) chk("rvalid_bound", data_rvalid, 1'b1);
    endtask

    task automatic drive_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
        data_req   = 1'b1;
        data_we    = we;
        data_addr  = addr;
        data_wdata = wdata;
        data_be    = be;
        req_cyc    = cyc;
    endtask

    task automatic obi_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input bit tmo);
        push_exp(we, addr, wdata, be, tmo);
        @(negedge clk);
        drive_req(we, addr, wdata, be);
        wait_gnt();
        @(negedge clk);
        data_req = 1'b0;
        wait_rvalid();
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_awvalid"}, m_awvalid, 1'b0);
        chk({tag, "_wvalid"}, m_wvalid, 1'b0);
        chk({tag, "_arvalid"}, m_arvalid, 1'b0);
        chk({tag, "_bready"}, m_bready, 1'b0);
        chk({tag, "_rready"}, m_rready, 1'b0);
        chk({tag, "_rvalid"}, data_rvalid, 1'b0);
        chk({tag, "_err"}, data_err, 1'b0);
        chk({tag, "_gnt"}, data_gnt, 1'b0);
        chk({tag, "_rdata"}, data_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_idle("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;

        // 1: read, all readies high, minimum latency
        rdata_cfg = 32'hDEAD_BEEF;
        rresp_cfg = 2'b00;
        gnt_log.delete(); rv_log.delete();
        obi_xfer(1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b0);
        chk("t1_araddr", cap_araddr, 32'h1000_0004);
        chk("t1_rdata", cap_rdata, 32'hDEAD_BEEF);
        chk("t1_err", cap_err, 1'b0);
        chk("t1_latency", rv_log[0] - gnt_log[0], 3);

        // 2: write, AW accepted two cycles before W
        aw_lat = 1; w_lat = 3; bresp_cfg = 2'b00;
        gnt_log.delete(); rv_log.delete();
        obi_xfer(1'b1, 32'h2000_0010, 32'hA5A5_5A5A, 4'b0110, 1'b0);
        chk("t2_wstrb", cap_wstrb, 4'b0110);
        chk("t2_wdata", cap_wdata, 32'hA5A5_5A5A);
        chk("t2_aw_cycle", aw_hs_cyc - gnt_log[0], 2);
        chk("t2_aw_to_w", w_hs_cyc - aw_hs_cyc, 2);
        chk("t2_err", cap_err, 1'b0);
        chk("t2_rdata", cap_rdata, 32'h0);
        aw_lat = 0; w_lat = 0;

        // 3: error responses on both channels
        bresp_cfg = 2'b10;
        obi_xfer(1'b1, 32'h3000_0000, 32'h1111_2222, 4'hF, 1'b0);
        chk("t3_slverr_wr", cap_err, 1'b1);
        rresp_cfg = 2'b11; rdata_cfg = 32'h1234_5678;
        obi_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1'b0);
        chk("t3_decerr_rd", cap_err, 1'b1);
        chk("t3_rdata", cap_rdata, 32'h1234_5678);
        bresp_cfg = 2'b11; w_lat = 1; b_lat = 2;
        obi_xfer(1'b1, 32'h3000_0010, 32'h0F0F_F0F0, 4'b1001, 1'b0);
        rresp_cfg = 2'b10; r_lat = 1; ar_lat = 1;
        obi_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1'b0);
        bresp_cfg = 2'b00; rresp_cfg = 2'b00; w_lat = 0; b_lat = 0; r_lat = 0; ar_lat = 0;

        // 4: back-to-back reads with request held high
        rdata_cfg = 32'hCAFE_0001;
        gnt_log.delete(); rv_log.delete();
        push_exp(1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b0);
        push_exp(1'b0, 32'h4000_0004, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        wait_gnt();
        @(negedge clk);
        data_addr = 32'h4000_0004;
        wait_gnt();
        @(negedge clk);
        data_req = 1'b0;
        wait_rvalid();
        chk("t4_second_gnt_after_rsp", gnt_log[1] - rv_log[0], 1);
        chk("t4_gnt_spacing", gnt_log[1] - gnt_log[0], 4);

        // 5: reset while waiting for the write response
        b_lat = 5;
        push_exp(1'b1, 32'h5000_0000, 32'h7777_8888, 4'hF, 1'b0);
        @(negedge clk);
        drive_req(1'b1, 32'h5000_0000, 32'h7777_8888, 4'hF);
        wait_gnt();
        @(negedge clk);
        data_req = 1'b0;
        begin
            int n = 0;
            while (!m_bready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t5_reached_wr_resp", m_bready, 1'b1);
        end
        chk_en = 0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        chk_all_idle("t5");
        @(negedge clk);
        rst_n = 1'b1;
        outst = 0;
        exp_q.delete();
        chk_en = 1;
        b_lat = 0;
        gnt_log.delete(); rv_log.delete();
        rdata_cfg = 32'h0BAD_F00D;
        obi_xfer(1'b0, 32'h5000_0004, 32'h0, 4'hF, 1'b0);
        chk("t5_idle_after_reset", gnt_log[0] - req_cyc, 0);
        chk("t5_read_after_reset", cap_rdata, 32'h0BAD_F00D);

`ifdef OBI_TO_AXIL_TIMEOUT_EN
        // 6: AR never accepted, watchdog answers, late R ignored
        ar_never = 1;
        obi_xfer(1'b0, 32'h6000_0000, 32'h0, 4'hF, 1'b1);
        chk("t6_err", cap_err, 1'b1);
        chk("t6_rdata", cap_rdata, 32'h0);
        ar_never = 0;
        @(negedge clk);
        r_force = 1;
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("t6_late_rready", m_rready, 1'b0);
            chk("t6_late_rvalid", data_rvalid, 1'b0);
        end
        r_force = 0;
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
